// File: rtl/text_pkg.sv
// Shared constants, state encoding and character helpers for the text SRAM loader.
package text_pkg;

  localparam logic [7:0] CH_ETX       = 8'h03;
  localparam logic [7:0] CH_SP        = 8'h20;
  localparam int         MAX_WORD_DEF = 5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    TERM,
    DONE
  } state_e;

  function automatic logic [7:0] fold_case(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
  endfunction

endpackage

// File: rtl/char_filter.sv
// Per-byte keep/drop decision for the text image: collapses spaces and truncates long words.
module char_filter
  import text_pkg::*;
#(
  parameter int MAX_WORD = MAX_WORD_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       keep_o,
  output logic       word_start_o,
  output logic       trunc_hit_o
);

  localparam int CNT_W = $clog2(MAX_WORD + 1);

  logic             in_word_q, in_word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_sp;
  logic             room;

  assign is_sp = (data_i == CH_SP);
  assign room  = (cnt_q < CNT_W'(MAX_WORD));

  always_comb begin
    keep_o       = 1'b0;
    word_start_o = 1'b0;
    trunc_hit_o  = 1'b0;
    in_word_d    = in_word_q;
    cnt_d        = cnt_q;
    if (valid_i) begin
      if (is_sp) begin
        // a space survives only directly after a word, even a truncated one
        keep_o    = in_word_q;
        in_word_d = 1'b0;
        cnt_d     = '0;
      end else begin
        in_word_d = 1'b1;
        if (room) begin
          keep_o       = 1'b1;
          word_start_o = (cnt_q == '0);
          cnt_d        = cnt_q + CNT_W'(1);
        end else begin
          trunc_hit_o = 1'b1;
        end
      end
    end
    if (clear_i) begin
      in_word_d = 1'b0;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      in_word_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      in_word_q <= in_word_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/text_loader.sv
// Writes a filtered, ETX-terminated text image into the text SRAM from a byte stream.
// Define CASE_FOLD_EN to fold lowercase letters to uppercase before writing.
module text_loader
  import text_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 1024,
  parameter int MAX_WORD = MAX_WORD_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              trunc,
  output logic [ADDR_W-1:0] word_count
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wc_q, wc_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              trunc_q, trunc_d;

  logic       accept, is_etx, full;
  logic       keep, word_start, trunc_hit;
  logic [7:0] char_out;

  // start wins over a byte offered in the same cycle, so never acknowledge it
  assign in_ready = (state_q == LOAD) && !start;
  assign accept   = in_valid && in_ready;
  assign is_etx   = (in_data == CH_ETX);
  assign full     = (addr_q == ADDR_W'(DEPTH - 1));

`ifdef CASE_FOLD_EN
  assign char_out = fold_case(in_data);
`else
  assign char_out = in_data;
`endif

  char_filter #(.MAX_WORD(MAX_WORD)) u_filter (
    .clock        (clock),
    .reset        (reset),
    .clear_i      (start),
    .valid_i      (accept && !is_etx),
    .data_i       (in_data),
    .keep_o       (keep),
    .word_start_o (word_start),
    .trunc_hit_o  (trunc_hit)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    wc_d    = wc_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    trunc_d = trunc_q;
    if (start) begin
      state_d = LOAD;
      addr_d  = '0;
      wc_d    = '0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
      trunc_d = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            if (!is_etx) begin
              if (full) begin
                ovf_d = 1'b1;
              end else if (keep) begin
                we_d    = 1'b1;
                waddr_d = addr_q;
                wdata_d = char_out;
                addr_d  = addr_q + ADDR_W'(1);
                if (word_start) wc_d = wc_q + ADDR_W'(1);
              end
              if (trunc_hit) trunc_d = 1'b1;
            end
            if (is_etx || in_last) state_d = TERM;
          end
        end
        TERM: begin
          // the last free location is reserved, so ETX always has a slot
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = CH_ETX;
          done_d  = 1'b1;
          state_d = DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      wc_q    <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      wc_q    <= wc_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      trunc_q <= trunc_d;
    end
  end

  assign sram_we    = we_q;
  assign sram_addr  = waddr_q;
  assign sram_wdata = wdata_q;
  assign busy       = (state_q == LOAD) || (state_q == TERM);
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign trunc      = trunc_q;
  assign word_count = wc_q;

endmodule
